// File: rtl/vram_dma.sv
// vram_dma: block-transfer engine between the system bus and the 8 KB LCD VRAM.
// Ports: clk/reset (sync, active-low), ce (CPU-rate enable); CPU register window
// dma_cs/cpu_rwn/AB/dbus_in/dbus_out; cpu_halt; system bus sys_addr/sys_rdata/
// sys_wdata/sys_we; VRAM port vram_addr/vram_rdata/vram_wdata/vram_we; irq.
// Optional completion interrupt enabled by defining VRAM_DMA_IRQ_EN.
module vram_dma #(
  parameter int VRAM_AW   = 13,
  parameter int BLK_BYTES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               dma_cs,
  input  logic               cpu_rwn,
  input  logic [5:0]         AB,
  input  logic [7:0]         dbus_in,
  output logic [7:0]         dbus_out,
  output logic               cpu_halt,
  output logic [15:0]        sys_addr,
  input  logic [7:0]         sys_rdata,
  output logic [7:0]         sys_wdata,
  output logic               sys_we,
  output logic [VRAM_AW-1:0] vram_addr,
  input  logic [7:0]         vram_rdata,
  output logic [7:0]         vram_wdata,
  output logic               vram_we,
  output logic               irq
);
  localparam int SW = $clog2(BLK_BYTES);
  localparam logic [VRAM_AW-1:0] V_ONE = 1;
  localparam logic [7+SW:0] R_ONE = 1;
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t state_q, state_d;
  logic [15:0] src_q, src_d, dst_q, dst_d;
  logic [7:0] len_q, len_d, data_q, data_d;
  logic [SW-1:0] sub_q, sub_d;
  logic dir_q, dir_d, halt_q, halt_d, we_q, we_d, reg_wr;
  // {len, sub} is the live remaining-byte count; all-zero at start means 256 blocks
  logic [7+SW:0] rem_dec;
  function automatic logic [15:0] vram_inc(input logic [15:0] p);
    vram_inc = p;
    vram_inc[VRAM_AW-1:0] = p[VRAM_AW-1:0] + V_ONE;
  endfunction
`ifdef VRAM_DMA_IRQ_EN
  logic irq_q, irq_d;
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    sub_d = sub_q;
    dir_d = dir_q;
    data_d = data_q;
    halt_d = halt_q;
    we_d = we_q;
`ifdef VRAM_DMA_IRQ_EN
    irq_d = (ce && dma_cs && AB == 6'h0D) ? 1'b0 : irq_q;
`endif
    rem_dec = {len_q, sub_q} - R_ONE;
    reg_wr = ce && dma_cs && !cpu_rwn && state_q == IDLE;
    if (reg_wr) begin
      src_d[7:0] = AB == 6'h08 ? dbus_in : src_q[7:0];
      src_d[15:8] = AB == 6'h09 ? dbus_in : src_q[15:8];
      dst_d[7:0] = AB == 6'h0A ? dbus_in : dst_q[7:0];
      dst_d[15:8] = AB == 6'h0B ? dbus_in : dst_q[15:8];
      len_d = AB == 6'h0C ? dbus_in : len_q;
      if (AB == 6'h0D) begin
        dir_d = dbus_in[6];
        if (dbus_in[7]) begin
          state_d = RD;
          halt_d = 1'b1;
          sub_d = '0;
        end
      end
    end
    if (ce && state_q == RD) begin
      data_d = dir_q ? vram_rdata : sys_rdata;
      we_d = 1'b1;
      state_d = WR;
    end
    if (ce && state_q == WR) begin
      src_d = dir_q ? vram_inc(src_q) : src_q + 16'd1;
      dst_d = dir_q ? dst_q + 16'd1 : vram_inc(dst_q);
      {len_d, sub_d} = rem_dec;
      we_d = 1'b0;
      state_d = rem_dec == '0 ? IDLE : RD;
      halt_d = rem_dec != '0;
`ifdef VRAM_DMA_IRQ_EN
      irq_d = rem_dec == '0 ? 1'b1 : irq_d;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      sub_q <= '0;
      dir_q <= 1'b0;
      data_q <= '0;
      halt_q <= 1'b0;
      we_q <= 1'b0;
`ifdef VRAM_DMA_IRQ_EN
      irq_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
      sub_q <= sub_d;
      dir_q <= dir_d;
      data_q <= data_d;
      halt_q <= halt_d;
      we_q <= we_d;
`ifdef VRAM_DMA_IRQ_EN
      irq_q <= irq_d;
`endif
    end
  end
  always_comb begin
    dbus_out = (!reset || !dma_cs) ? 8'h00 :
               AB == 6'h08 ? src_q[7:0] :
               AB == 6'h09 ? src_q[15:8] :
               AB == 6'h0A ? dst_q[7:0] :
               AB == 6'h0B ? dst_q[15:8] :
               AB == 6'h0C ? len_q :
               AB == 6'h0D ? {halt_q, dir_q, 6'b0} : 8'h00;
  end
  // source and destination roles of the two pointers swap with dir
  assign sys_addr = dir_q ? dst_q : src_q;
  assign vram_addr = dir_q ? src_q[VRAM_AW-1:0] : dst_q[VRAM_AW-1:0];
  assign cpu_halt = halt_q;
  assign vram_we = we_q & ~dir_q;
  assign sys_we = we_q & dir_q;
  assign vram_wdata = data_q;
  assign sys_wdata = data_q;
endmodule

// File: tb/tb_vram_dma.sv
// tb_vram_dma: table-driven, hand-written and randomized checks of vram_dma against a transfer model.
module tb_vram_dma;
  logic clk = 1'b0, reset = 1'b0, ce = 1'b0, dma_cs = 1'b0, cpu_rwn = 1'b1;
  logic [5:0] AB = '0;
  logic [7:0] dbus_in = '0;
  logic [7:0] dbus_out, sys_rdata, sys_wdata, vram_rdata, vram_wdata;
  logic [15:0] sys_addr;
  logic [12:0] vram_addr;
  logic cpu_halt, sys_we, vram_we, irq;
  logic [7:0] sys_mem [65536];
  logic [7:0] vram_mem [8192];
  typedef struct {logic [15:0] a; logic [7:0] d; logic to_sys;} wr_t;
  wr_t wlog[$];
  typedef struct {
    logic [15:0] src, dst;
    logic [7:0] len, ctrl;
    logic [15:0] exp_src, exp_dst;
    int exp_n;
  } vec_t;
  vec_t vecs[5];
  int halt_cnt = 0, stray = 0, total = 0, passed = 0;
  logic gaps = 1'b0;

  always #5 clk = ~clk;
  assign sys_rdata = sys_mem[sys_addr];
  assign vram_rdata = vram_mem[vram_addr];

  vram_dma dut (
    .clk(clk), .reset(reset), .ce(ce), .dma_cs(dma_cs), .cpu_rwn(cpu_rwn), .AB(AB),
    .dbus_in(dbus_in), .dbus_out(dbus_out), .cpu_halt(cpu_halt), .sys_addr(sys_addr),
    .sys_rdata(sys_rdata), .sys_wdata(sys_wdata), .sys_we(sys_we), .vram_addr(vram_addr),
    .vram_rdata(vram_rdata), .vram_wdata(vram_wdata), .vram_we(vram_we), .irq(irq)
  );

  // strobes are consumed on ce ticks; sample mid-cycle, ahead of the edge that takes them
  always @(negedge clk) if (reset && ce) begin
    if (vram_we) wlog.push_back(wr_t'{a: {3'b0, vram_addr}, d: vram_wdata, to_sys: 1'b0});
    if (sys_we) wlog.push_back(wr_t'{a: sys_addr, d: sys_wdata, to_sys: 1'b1});
    if (cpu_halt) halt_cnt++;
    if (((vram_we || sys_we) && !cpu_halt) || (vram_we && sys_we)) stray++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    ce = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
    @(posedge clk); #1;
    ce = 1'b0;
  endtask

  task automatic cpu_write(input logic [5:0] a, input logic [7:0] d);
    dma_cs = 1'b1; cpu_rwn = 1'b0; AB = a; dbus_in = d; ce = 1'b1;
    @(posedge clk); #1;
    dma_cs = 1'b0; cpu_rwn = 1'b1; ce = 1'b0;
  endtask

  task automatic cpu_read(input logic [5:0] a, output logic [7:0] d);
    dma_cs = 1'b1; cpu_rwn = 1'b1; AB = a; ce = 1'b1;
    #2 d = dbus_out;
    @(posedge clk); #1;
    dma_cs = 1'b0; ce = 1'b0;
  endtask

  task automatic rd16(input logic [5:0] a, output logic [15:0] v);
    logic [7:0] lo, hi;
    cpu_read(a, lo);
    cpu_read(a + 6'd1, hi);
    v = {hi, lo};
  endtask

  task automatic start(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l, input logic [7:0] c);
    wlog.delete();
    halt_cnt = 0;
    cpu_write(6'h08, s[7:0]);
    cpu_write(6'h09, s[15:8]);
    cpu_write(6'h0A, d[7:0]);
    cpu_write(6'h0B, d[15:8]);
    cpu_write(6'h0C, l);
    cpu_write(6'h0D, c);
  endtask

  // model: byte i goes from source+i to destination+i, VRAM side modulo 8192, system side modulo 65536
  task automatic finish(input logic [15:0] s, input logic [15:0] d, input logic [7:0] c,
                        input logic [15:0] es, input logic [15:0] ed, input int n);
    int k, bad, ea;
    logic [7:0] exp_d, b;
    logic [15:0] v;
    k = 0;
    while (cpu_halt && k < 25000) begin tick(); k++; end
    check("xfer_done", cpu_halt, 0);
    check("wr_count", wlog.size(), n);
    bad = 0;
    for (int i = 0; i < wlog.size(); i++) begin
      ea = c[6] ? (d + i) % 65536 : (d + i) % 8192;
      exp_d = c[6] ? vram_mem[(s + i) % 8192] : sys_mem[(s + i) % 65536];
      if (i >= n || wlog[i].a != ea[15:0] || wlog[i].d != exp_d || wlog[i].to_sys != c[6]) bad++;
    end
    check("wr_stream_errors", bad, 0);
    check("halt_ce", halt_cnt, 2 * n);
    rd16(6'h08, v);
    check("src_end", v, es);
    rd16(6'h0A, v);
    check("dst_end", v, ed);
    cpu_read(6'h0C, b);
    check("len_end", b, 0);
`ifdef VRAM_DMA_IRQ_EN
    check("irq_set", irq, 1);
`else
    check("irq_zero", irq, 0);
`endif
    cpu_read(6'h0D, b);
    check("ctrl_end", b, c[6] ? 8'h40 : 8'h00);
    check("irq_after_ctrl_read", irq, 0);
  endtask

  initial begin
    logic [7:0] b, acc;
    logic [15:0] v, s, d, es, ed;
    logic [7:0] c, l;
    int n, n0, k;
    for (int i = 0; i < 65536; i++) sys_mem[i] = 8'($urandom);
    for (int i = 0; i < 8192; i++) vram_mem[i] = 8'($urandom);
    vecs[0] = '{src: 16'h8000, dst: 16'h0000, len: 8'd1, ctrl: 8'h80, exp_src: 16'h8010, exp_dst: 16'h0010, exp_n: 16};
    vecs[1] = '{src: 16'h1234, dst: 16'h1FF8, len: 8'd1, ctrl: 8'h80, exp_src: 16'h1244, exp_dst: 16'h0008, exp_n: 16};
    vecs[2] = '{src: 16'hFF00, dst: 16'h0000, len: 8'd0, ctrl: 8'h80, exp_src: 16'h0F00, exp_dst: 16'h1000, exp_n: 4096};
    vecs[3] = '{src: 16'h0100, dst: 16'h4000, len: 8'd2, ctrl: 8'hC0, exp_src: 16'h0120, exp_dst: 16'h4020, exp_n: 32};
    vecs[4] = '{src: 16'h1FF0, dst: 16'hFFF0, len: 8'd2, ctrl: 8'hC0, exp_src: 16'h0010, exp_dst: 16'h0010, exp_n: 32};
    // reset state, with ce low to show reset does not need it
    dma_cs = 1'b1; AB = 6'h0D;
    repeat (3) @(posedge clk);
    #1;
    check("rst_halt", cpu_halt, 0);
    check("rst_vram_we", vram_we, 0);
    check("rst_sys_we", sys_we, 0);
    check("rst_irq", irq, 0);
    check("rst_dbus", dbus_out, 0);
    dma_cs = 1'b0;
    reset = 1'b1;
    cpu_read(6'h0D, b);
    check("rst_ctrl", b, 0);
    // register readback and unmapped addresses while idle
    cpu_write(6'h08, 8'h5A); cpu_write(6'h09, 8'hA5);
    cpu_write(6'h0A, 8'h34); cpu_write(6'h0B, 8'h12); cpu_write(6'h0C, 8'h07);
    rd16(6'h08, v); check("rb_src", v, 16'hA55A);
    rd16(6'h0A, v); check("rb_dst", v, 16'h1234);
    cpu_read(6'h0C, b); check("rb_len", b, 8'h07);
    cpu_read(6'h00, b); check("rb_unmapped_00", b, 0);
    cpu_read(6'h0E, b); check("rb_unmapped_0e", b, 0);
    // ctrl with start clear only sets dir
    wlog.delete();
    cpu_write(6'h0D, 8'h40);
    repeat (6) tick();
    check("nostart_halt", cpu_halt, 0);
    check("nostart_wr", wlog.size(), 0);
    cpu_read(6'h0D, b); check("nostart_ctrl", b, 8'h40);
    cpu_write(6'h0D, 8'h00);
    // table-driven transfers
    for (int i = 0; i < 5; i++) begin
      gaps = i[0];
      start(vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].ctrl);
      finish(vecs[i].src, vecs[i].dst, vecs[i].ctrl, vecs[i].exp_src, vecs[i].exp_dst, vecs[i].exp_n);
    end
    // randomized transfers against the model
    gaps = 1'b1;
    for (int r = 0; r < 6; r++) begin
      l = 8'($urandom_range(1, 3));
      c = $urandom_range(0, 1) != 0 ? 8'hC0 : 8'h80;
      n = l * 16;
      s = c[6] ? 16'($urandom_range(0, 8191)) : 16'($urandom);
      d = c[6] ? 16'($urandom) : 16'($urandom_range(0, 8191));
      es = c[6] ? 16'((s + n) % 8192) : 16'((s + n) % 65536);
      ed = c[6] ? 16'((d + n) % 65536) : 16'((d + n) % 8192);
      start(s, d, l, c);
      finish(s, d, c, es, ed, n);
    end
    // writes while busy are ignored; ce low freezes the engine
    gaps = 1'b0;
    start(16'h2000, 16'h0100, 8'd1, 8'h80);
    repeat (4) tick();
    cpu_write(6'h0C, 8'h05);
    cpu_write(6'h0D, 8'hC0);
    cpu_write(6'h08, 8'hAA);
    n0 = wlog.size();
    repeat (10) @(posedge clk);
    #1;
    check("ce_freeze_wr", wlog.size(), n0);
    check("ce_freeze_halt", cpu_halt, 1);
    finish(16'h2000, 16'h0100, 8'h80, 16'h2010, 16'h0110, 16);
    // reset at byte 7 drops the transfer
    start(16'h3000, 16'h0200, 8'd1, 8'h80);
    k = 0;
    while (wlog.size() < 7 && k < 100) begin tick(); k++; end
    check("reach_byte7", wlog.size(), 7);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("mid_rst_halt", cpu_halt, 0);
    check("mid_rst_vram_we", vram_we, 0);
    check("mid_rst_irq", irq, 0);
    wlog.delete();
    repeat (40) tick();
    check("post_rst_wr", wlog.size(), 0);
    check("post_rst_halt", cpu_halt, 0);
    acc = 8'h00;
    for (int a = 8; a < 14; a++) begin
      cpu_read(6'(a), b);
      acc = acc | b;
    end
    check("post_rst_regs", acc, 0);
    check("stray_strobes", stray, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
